// File: rtl/key_conditioner_if.sv
// rtl/key_conditioner_if.sv - Button-side and processor-side signal bundle of key_conditioner
interface key_conditioner_if #(
    parameter int NUM_KEYS = 3
);
    logic [NUM_KEYS-1:0] key_n_in;
    logic [NUM_KEYS-1:0] event_clear;
    logic [NUM_KEYS-1:0] keys_export_n;
    logic [NUM_KEYS-1:0] key_level;
    logic [NUM_KEYS-1:0] key_press;
    logic [NUM_KEYS-1:0] key_release;
    logic [NUM_KEYS-1:0] key_long;
    logic [NUM_KEYS-1:0] event_sticky;

    modport master (
        output key_n_in,
        output event_clear,
        input  keys_export_n,
        input  key_level,
        input  key_press,
        input  key_release,
        input  key_long,
        input  event_sticky
    );

    modport slave (
        input  key_n_in,
        input  event_clear,
        output keys_export_n,
        output key_level,
        output key_press,
        output key_release,
        output key_long,
        output event_sticky
    );
endinterface

// File: rtl/key_conditioner.sv
// rtl/key_conditioner.sv - Per-key synchronizer, debounce FSM, press/release/long pulses and sticky flags
module key_conditioner #(
    parameter int NUM_KEYS          = 3,
    parameter int DEBOUNCE_CYCLES   = 1000000,
    parameter int LONG_PRESS_CYCLES = 50000000
) (
    input  logic              clk,
    input  logic              reset,
    key_conditioner_if.slave  keys
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int HW = $clog2(LONG_PRESS_CYCLES);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;

    logic [NUM_KEYS-1:0] sync_meta;
    logic [NUM_KEYS-1:0] sync_n;

    // Synchronizers reset to the released level so no phantom press follows reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_meta <= '1;
            sync_n    <= '1;
        end else begin
            sync_meta <= keys.key_n_in;
            sync_n    <= sync_meta;
        end
    end

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        state_t        state;
        logic [DW-1:0] db_cnt;
        logic [HW-1:0] hold_cnt;
        logic [HW-1:0] hold_inc;
        logic          long_fired;
        logic          level;
        logic          press;
        logic          release_p;
        logic          long_p;
        logic          sticky;
        logic          accept;

        assign hold_inc = hold_cnt + 1'b1;
        assign accept   = (state == PRESS_WAIT) && !sync_n[k] && (db_cnt == DB_LAST);

        always_ff @(posedge clk) begin
            if (reset) begin
                state      <= IDLE;
                db_cnt     <= '0;
                hold_cnt   <= '0;
                long_fired <= 1'b0;
                level      <= 1'b0;
                press      <= 1'b0;
                release_p  <= 1'b0;
                long_p     <= 1'b0;
                sticky     <= 1'b0;
            end else begin
                press     <= 1'b0;
                release_p <= 1'b0;
                long_p    <= 1'b0;
                case (state)
                    IDLE: begin
                        if (!sync_n[k]) begin
                            state  <= PRESS_WAIT;
                            db_cnt <= '0;
                        end
                    end
                    PRESS_WAIT: begin
                        if (sync_n[k]) begin
                            state <= IDLE;
                        end else if (db_cnt == DB_LAST) begin
                            state      <= PRESSED;
                            level      <= 1'b1;
                            press      <= 1'b1;
                            hold_cnt   <= '0;
                            long_fired <= 1'b0;
                        end else begin
                            db_cnt <= db_cnt + 1'b1;
                        end
                    end
                    PRESSED: begin
                        if (hold_cnt != HOLD_LAST) begin
                            hold_cnt <= hold_inc;
                            if (hold_inc == HOLD_LAST && !long_fired) begin
                                long_p     <= 1'b1;
                                long_fired <= 1'b1;
                            end
                        end
                        if (sync_n[k]) begin
                            state  <= RELEASE_WAIT;
                            db_cnt <= '0;
                        end
                    end
                    RELEASE_WAIT: begin
                        // Hold count and long_fired survive a release bounce.
                        if (!sync_n[k]) begin
                            state <= PRESSED;
                        end else if (db_cnt == DB_LAST) begin
                            state     <= IDLE;
                            level     <= 1'b0;
                            release_p <= 1'b1;
                        end else begin
                            db_cnt <= db_cnt + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
                // Set wins over clear both on the accepting edge and while the press pulse is visible.
                sticky <= (sticky & ~keys.event_clear[k]) | accept | press;
            end
        end

        assign keys.key_level[k]     = level;
        assign keys.keys_export_n[k] = ~level;
        assign keys.key_press[k]     = press;
        assign keys.key_release[k]   = release_p;
        assign keys.key_long[k]      = long_p;
        assign keys.event_sticky[k]  = sticky;
    end
endmodule

// File: tb/tb_key_conditioner.sv
// tb/tb_key_conditioner.sv - Scoreboard bench for key_conditioner with directed button vectors
module tb_key_conditioner;
    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   t;

    typedef struct {
        int         cyc;
        logic [2:0] p;
        logic [2:0] r;
        logic [2:0] l;
    } ev_t;

    ev_t exp_q[$];

    key_conditioner_if #(.NUM_KEYS(3)) kif ();

    key_conditioner #(
        .NUM_KEYS(3),
        .DEBOUNCE_CYCLES(4),
        .LONG_PRESS_CYCLES(10)
    ) dut (
        .clk(clk),
        .reset(reset),
        .keys(kif)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic push(input int c, input logic [2:0] p, input logic [2:0] r, input logic [2:0] l);
        ev_t e;
        e.cyc = c; e.p = p; e.r = r; e.l = l;
        exp_q.push_back(e);
    endtask

    task automatic check3(input string name, input logic [2:0] act, input logic [2:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%b required=%b", name, cyc, act, req);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check3({tag, "_export"}, kif.keys_export_n, 3'b111);
        check3({tag, "_level"},  kif.key_level,     3'b000);
        check3({tag, "_sticky"}, kif.event_sticky,  3'b000);
        check3({tag, "_pulses"}, kif.key_press | kif.key_release | kif.key_long, 3'b000);
    endtask

    initial begin
        reset           = 1'b1;
        kif.key_n_in    = 3'b111;
        kif.event_clear = 3'b000;

        fork
            forever begin
                ev_t e;
                @(negedge clk);
                if ((kif.key_press | kif.key_release | kif.key_long) != 3'b000) begin
                    n_tests++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_pulse cyc=%0d press=%b release=%b long=%b required=none",
                                 cyc, kif.key_press, kif.key_release, kif.key_long);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.cyc != cyc || e.p !== kif.key_press || e.r !== kif.key_release || e.l !== kif.key_long) begin
                            n_fail++;
                            $display("FAIL pulse_event actual cyc=%0d p=%b r=%b l=%b required cyc=%0d p=%b r=%b l=%b",
                                     cyc, kif.key_press, kif.key_release, kif.key_long, e.cyc, e.p, e.r, e.l);
                        end
                    end
                end
            end
        join_none

        repeat (3) @(negedge clk);
        check_reset_state("reset");
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Clean press on key 0, sticky set/clear priority, release bounce, final release
        t = cyc;
        kif.key_n_in[0] = 1'b0;
        push(t + 7,  3'b001, 3'b000, 3'b000);
        push(t + 16, 3'b000, 3'b000, 3'b001);
        wait_until(t + 7);
        kif.event_clear = 3'b001;
        wait_until(t + 8);
        kif.event_clear = 3'b000;
        check3("press0_level",  kif.key_level,     3'b001);
        check3("press0_export", kif.keys_export_n, 3'b110);
        check3("sticky_set_beats_clear", kif.event_sticky, 3'b001);
        wait_until(t + 11);
        kif.event_clear = 3'b001;
        wait_until(t + 12);
        kif.event_clear = 3'b000;
        check3("sticky_clear", kif.event_sticky, 3'b000);
        wait_until(t + 20);
        kif.key_n_in[0] = 1'b1;
        wait_until(t + 22);
        kif.key_n_in[0] = 1'b0;
        wait_until(t + 28);
        check3("release_bounce_level", kif.key_level, 3'b001);
        wait_until(t + 30);
        kif.key_n_in[0] = 1'b1;
        push(t + 37, 3'b000, 3'b001, 3'b000);
        wait_until(t + 38);
        check3("release0_level",  kif.key_level,     3'b000);
        check3("release0_export", kif.keys_export_n, 3'b111);

        // Bounce on key 1: 2-cycle phases never reach the debounce count
        for (int i = 0; i < 10; i++) begin
            kif.key_n_in[1] = (i % 2 == 0) ? 1'b0 : 1'b1;
            repeat (2) @(negedge clk);
            check3("bounce_level", kif.key_level, 3'b000);
        end
        kif.key_n_in[1] = 1'b1;
        repeat (8) @(negedge clk);
        check3("bounce_sticky", kif.event_sticky, 3'b000);

        // Long press on key 2 held 30 cycles
        t = cyc;
        kif.key_n_in[2] = 1'b0;
        push(t + 7,  3'b100, 3'b000, 3'b000);
        push(t + 16, 3'b000, 3'b000, 3'b100);
        wait_until(t + 30);
        check3("long2_level", kif.key_level, 3'b100);
        kif.key_n_in[2] = 1'b1;
        push(t + 37, 3'b000, 3'b100, 3'b000);
        wait_until(t + 40);
        check3("long2_released", kif.key_level, 3'b000);

        // Reset while key 1 is pressed and held, then fresh debounce
        t = cyc;
        kif.key_n_in[1] = 1'b0;
        push(t + 7, 3'b010, 3'b000, 3'b000);
        wait_until(t + 10);
        check3("pre_reset_level", kif.key_level, 3'b010);
        reset = 1'b1;
        wait_until(t + 11);
        check_reset_state("midreset");
        reset = 1'b0;
        push(t + 18, 3'b010, 3'b000, 3'b000);
        wait_until(t + 19);
        check3("post_reset_level", kif.key_level, 3'b010);
        check3("post_reset_sticky", kif.event_sticky, 3'b010);
        wait_until(t + 20);
        kif.key_n_in[1] = 1'b1;
        push(t + 27, 3'b000, 3'b010, 3'b000);
        wait_until(t + 35);

        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL missing_pulses actual_pending=%0d required=0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
